// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcode and FSM state enums plus the
// shift-class decoder used by the control path.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_ROR   = 3'b010,
    OP_ROL   = 3'b011,
    OP_NAND  = 3'b100,
    OP_XOR   = 3'b101,
    OP_SHR   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_ROR) || (op == OP_ROL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/result bundle between the register-file read side and alu_iter.
interface alu_iter_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       alu_cmd;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             sc_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rslt;
  logic             sc_o;
  logic             pari;
  logic             zero;
  logic             neq;

  modport master (output start, alu_cmd, inA, inB, sc_i,
                  input  busy, done, rslt, sc_o, pari, zero, neq);
  modport slave  (input  start, alu_cmd, inA, inB, sc_i,
                  output busy, done, rslt, sc_o, pari, zero, neq);
endinterface

// File: rtl/alu_shift_step.sv
// One-bit ROR/ROL/SHR step; non-shift opcodes pass the value through.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  alu_op_t          op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] val_o,
  output logic             bit_o
);

  always_comb begin
    val_o = val_i;
    bit_o = 1'b0;
    case (op_i)
      OP_ROR: begin
        val_o = {val_i[0], val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      OP_ROL: begin
        val_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
        bit_o = val_i[WIDTH-1];
      end
      OP_SHR: begin
        val_o = {fill_i, val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Clocked ALU: single-cycle arithmetic/logic, iterative one-bit-per-cycle shifts.
// Define ALU_ITER_BARREL_SHIFT_EN to resolve shifts combinationally in one cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_iter_if.slave  bus
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  alu_state_t       state_q;
  logic [WIDTH-1:0] rslt_q;
  logic             sc_q, pari_q, zero_q, neq_q, done_q;

  alu_op_t          op_in;
  logic [31:0]      amt_full;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] res_d;
  logic             c_d;

  assign op_in    = alu_op_t'(bus.alu_cmd);
  // Exact modulo so non-power-of-two widths wrap correctly.
  assign amt_full = 32'(bus.inB) % 32'(WIDTH);
  assign amt      = amt_full[CNT_W-1:0];

`ifdef ALU_ITER_BARREL_SHIFT_EN
  logic [WIDTH-1:0] stg [WIDTH];
  logic [WIDTH-2:0] bo;

  assign stg[0] = bus.inA;
  for (genvar k = 0; k < WIDTH-1; k++) begin : g_chain
    alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .val_i (stg[k]),
      .op_i  (op_in),
      .fill_i(bus.sc_i),
      .val_o (stg[k+1]),
      .bit_o (bo[k])
    );
  end
`else
  logic [WIDTH-1:0] w_q, w_nxt;
  logic [CNT_W-1:0] cnt_q;
  alu_op_t          op_q;
  logic             fill_q, neq_p_q, w_bit;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i (w_q),
    .op_i  (op_q),
    .fill_i(fill_q),
    .val_o (w_nxt),
    .bit_o (w_bit)
  );
`endif

  // Single-cycle result, taken straight from the request operands.
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    case (op_in)
      OP_ADD:   {c_d, res_d} = {1'b0, bus.inA} + {1'b0, bus.inB};
      OP_SUB:   {c_d, res_d} = {1'b0, bus.inA} + {1'b0, ~bus.inB} + ONE;
      OP_NAND:  res_d = ~(bus.inA & bus.inB);
      OP_XOR:   res_d = bus.inA ^ bus.inB;
      OP_PASSB: res_d = bus.inB;
      default: begin
        res_d = bus.inA;
`ifdef ALU_ITER_BARREL_SHIFT_EN
        for (int k = 1; k < WIDTH; k++)
          if (amt == CNT_W'(k)) begin
            res_d = stg[k];
            c_d   = bo[k-1];
          end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rslt_q  <= '0;
      sc_q    <= 1'b0;
      pari_q  <= 1'b0;
      zero_q  <= 1'b1;
      neq_q   <= 1'b0;
      done_q  <= 1'b0;
`ifndef ALU_ITER_BARREL_SHIFT_EN
      w_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      fill_q  <= 1'b0;
      neq_p_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start) begin
`ifndef ALU_ITER_BARREL_SHIFT_EN
          if (is_shift(op_in) && amt != '0) begin
            w_q     <= bus.inA;
            cnt_q   <= amt;
            op_q    <= op_in;
            fill_q  <= bus.sc_i;
            neq_p_q <= (bus.inA != bus.inB);
            state_q <= ST_SHIFT;
          end else
`endif
          begin
            rslt_q  <= res_d;
            sc_q    <= c_d;
            zero_q  <= (res_d == '0);
            pari_q  <= ^res_d;
            neq_q   <= (bus.inA != bus.inB);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`ifndef ALU_ITER_BARREL_SHIFT_EN
        ST_SHIFT: begin
          w_q   <= w_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rslt_q  <= w_nxt;
            sc_q    <= w_bit;
            zero_q  <= (w_nxt == '0);
            pari_q  <= ^w_nxt;
            neq_q   <= neq_p_q;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = done_q;
  assign bus.rslt = rslt_q;
  assign bus.sc_o = sc_q;
  assign bus.pari = pari_q;
  assign bus.zero = zero_q;
  assign bus.neq  = neq_q;

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, clocked successor to the datapath ALU: WIDTH-bit operands, 3-bit opcode, start/busy/done handshake.
- Single-cycle execution for arithmetic and logic ops; shift/rotate is iterative, one bit per cycle.
- Result and flags (carry, zero, parity, neq) are registered and held until the next operation completes.
- Sits between the register file read ports and the writeback mux; the control FSM stalls on busy.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH)+1, width of the internal shift-amount counter (derived; not to be overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request; sampled only while busy=0.
- alu_cmd  input  3  opcode, sampled with start.
- inA  input  WIDTH  operand A, sampled with start.
- inB  input  WIDTH  operand B or shift amount, sampled with start.
- sc_i  input  1  shift carry in (SHR fill bit), sampled with start.
- busy  output  1  high while an op is in flight (ST_SHIFT).
- done  output  1  one-cycle pulse; rslt/flags valid from this cycle.
- rslt  output  WIDTH  registered result.
- sc_o  output  1  registered carry/shift-out.
- pari  output  1  registered XOR-reduction of rslt.
- zero  output  1  registered (rslt == 0).
- neq  output  1  registered (inA != inB) of latched operands.

Behaviour:
- Reset: state=ST_IDLE; busy=0, done=0, rslt=0, sc_o=0, pari=0, neq=0, zero=1. Reset mid-operation aborts the op; no done pulse.
- Opcodes:
  - 000 ADD: A+B, sc_o=carry out.
  - 001 SUB: A+~B+1, sc_o=carry out (1 = no borrow).
  - 010 ROR by amt.
  - 011 ROL by amt.
  - 100 NAND.
  - 101 XOR.
  - 110 SHR by amt, filling MSB with latched sc_i each step.
  - 111 PASSB: rslt=B, sc_o=0.
- Shift amount: amt = inB mod WIDTH, computed once at accept; the modulo is exact for non-power-of-two WIDTH.
- States:
  - ST_IDLE: on start, latch operands and opcode.
    - Non-shift op, or shift op with amt=0: go to ST_DONE; for amt=0, rslt=A and sc_o=0.
    - Shift op with amt>0: load the counter with amt and go to ST_SHIFT.
  - ST_SHIFT: busy=1. Each cycle performs a one-bit step and decrements the counter. sc_o takes the bit moved out of the word on that step. At counter==1, the final step completes and the state goes to ST_DONE.
  - ST_DONE: outputs already updated on entry; done=1 for this cycle only; return to ST_IDLE. busy=0 here, and a new start is not accepted until ST_IDLE.
- Latency: start edge to done = 1 cycle for non-shift ops and amt=0; amt+1 cycles for shifts. Throughput: one op per 2+amt cycles.
- start while busy=1 or in ST_DONE: ignored, not queued.
- Flags zero/pari derive from the final rslt. neq derives from the latched operands. All update together with rslt on entry to ST_DONE; held otherwise.
- Arithmetic is modulo 2^WIDTH, with no overflow flag.
- Undriven X on unused inputs while idle must not propagate into outputs.

Optional Feature:
- Macro: ALU_ITER_BARREL_SHIFT_EN.
- Defined: ROR/ROL/SHR are computed combinationally in one step; latency 1 for all ops; ST_SHIFT unreachable; busy never asserts. sc_o and results are identical to the iterative path.
- Undefined: iterative behaviour as above.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t (OP_ADD..OP_PASSB).
  - typedef enum logic [1:0] alu_state_t (ST_IDLE, ST_SHIFT, ST_DONE).
  - Opcode constants used by the control decoder.
- One sub-module, alu_shift_step: combinational single-bit ROR/ROL/SHR step (inputs: value, op, fill bit; outputs: next value, bit out). Instantiated once in the iterative path, or chained WIDTH-1 deep under the barrel macro.

Test Plan (WIDTH=8):
- ADD A=0xFF, B=0x01 -> 1 cycle later: done=1, rslt=0x00, sc_o=1, zero=1, pari=0, neq=1.
- SUB A=0x05, B=0x05 -> rslt=0x00, sc_o=1, zero=1, neq=0. SUB A=0x03, B=0x05 -> rslt=0xFE, sc_o=0, pari=1.
- ROR A=0x81, B=0x01 -> busy 1 cycle, done 2 cycles after start, rslt=0xC0, sc_o=1. ROL A=0x81, B=0x09 -> amt=1, rslt=0x03, sc_o=1.
- SHR A=0x00, B=0x03, sc_i=1 -> done after 4 cycles, rslt=0xE0, sc_o=0. ROR B=0x08 -> amt=0, latency 1, rslt=A, sc_o=0.
- Start pulses during busy (ROR by 7) with different operands -> ignored; single done, result of the first op only.
- reset asserted mid-ROR (cycle 3) -> next cycle all outputs at reset values, no done. Fresh NAND A=0xF0, B=0x3C then yields rslt=0xCF.
